// File: rtl/fir_stream_engine_if.sv
// AXI-Lite control bus plus AXI-Stream input/output channels for fir_stream_engine.
// The engine connects through the slave modport; the driver (testbench/host) uses master.
interface fir_stream_engine_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;
  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output awready, wready, arready, rvalid, rdata,
           ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  awready, wready, arready, rvalid, rdata,
           ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/fir_stream_engine.sv
// Streaming FIR filter with AXI-Lite configuration, one multiply-accumulate per cycle.
// Define FIR_SATURATE_EN to clamp outputs to the signed data range instead of wrapping.
module fir_stream_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int NTAP        = 11
) (
  input logic                axis_clk,
  input logic                axis_rst,
  fir_stream_engine_if.slave bus
);

  localparam int DW   = pDATA_WIDTH;
  localparam int AW   = pADDR_WIDTH;
  localparam int TIW  = $clog2(NTAP);
  localparam int ACCW = 2 * DW + $clog2(NTAP);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_WAIT_IN = 3'd2;
  localparam logic [2:0] S_MAC     = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam logic [AW-1:0]  ADDR_CTRL = AW'(32'h00);
  localparam logic [AW-1:0]  ADDR_LEN  = AW'(32'h10);
  localparam logic [AW-1:0]  TAP_BASE  = AW'(32'h20);
  localparam logic [TIW-1:0] LAST_TAP  = TIW'(NTAP - 1);

  logic                   wrAck_q, arAck_q, rvalid_q, rdCtrl_q;
  logic [DW-1:0]          rdata_q;
  logic                   apStart_q, apStart_d;
  logic                   apDone_q, apDone_d;
  logic                   apIdle_q, apIdle_d;
  logic [DW-1:0]          dataLen_q;
  logic [DW-1:0]          outCnt_q, outCnt_d;
  logic [DW-1:0]          tap_q  [NTAP];
  logic [DW-1:0]          hist_q [NTAP];
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [2:0]             state_q, state_d;
  logic [TIW-1:0]         cnt_q, cnt_d;
  logic                   lastIn_q, lastIn_d;
  logic                   smValid_q, smValid_d;
  logic                   smLast_q, smLast_d;
  logic [DW-1:0]          smData_q, smData_d;

  logic                   wrFire, wrIsTap, rdIsTap;
  logic [AW-1:0]          wrTapOff, rdTapOff;
  logic [TIW-1:0]         wrTapIdx, rdTapIdx;
  logic [DW-1:0]          rdMux;
  logic                   histClr, histShift;
  logic signed [2*DW-1:0] tapExt, histExt, prod;
  logic signed [ACCW-1:0] accSum;
  logic [DW-1:0]          outVal;

  assign wrFire = wrAck_q & bus.awvalid & bus.wvalid;

  always_comb begin
    wrTapOff = bus.awaddr - TAP_BASE;
    rdTapOff = bus.araddr - TAP_BASE;
    wrIsTap  = (bus.awaddr >= TAP_BASE) && (wrTapOff[1:0] == 2'b00) &&
               ((wrTapOff >> 2) < AW'(NTAP));
    rdIsTap  = (bus.araddr >= TAP_BASE) && (rdTapOff[1:0] == 2'b00) &&
               ((rdTapOff >> 2) < AW'(NTAP));
    wrTapIdx = wrTapOff[TIW+1:2];
    rdTapIdx = rdTapOff[TIW+1:2];
    rdMux    = '0;
    if (bus.araddr == ADDR_CTRL) rdMux = DW'({apIdle_q, apDone_q, apStart_q});
    else if (bus.araddr == ADDR_LEN) rdMux = dataLen_q;
    else if (rdIsTap) rdMux = tap_q[rdTapIdx];
  end

  // Single shared multiplier: the tap index doubles as the history index.
  always_comb begin
    tapExt  = {{DW{tap_q[cnt_q][DW-1]}}, tap_q[cnt_q]};
    histExt = {{DW{hist_q[cnt_q][DW-1]}}, hist_q[cnt_q]};
    prod    = tapExt * histExt;
    accSum  = acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
`ifdef FIR_SATURATE_EN
    if ((accSum[ACCW-1:DW-1] == '0) || (accSum[ACCW-1:DW-1] == '1)) outVal = accSum[DW-1:0];
    else if (accSum[ACCW-1]) outVal = {1'b1, {(DW-1){1'b0}}};
    else outVal = {1'b0, {(DW-1){1'b1}}};
`else
    outVal = accSum[DW-1:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    outCnt_d  = outCnt_q;
    lastIn_d  = lastIn_q;
    smValid_d = smValid_q;
    smData_d  = smData_q;
    smLast_d  = smLast_q;
    apStart_d = apStart_q;
    apDone_d  = apDone_q;
    apIdle_d  = apIdle_q;
    histClr   = 1'b0;
    histShift = 1'b0;
    if (rvalid_q && bus.rready && rdCtrl_q) apDone_d = 1'b0;
    if (wrFire && (bus.awaddr == ADDR_CTRL) && bus.wdata[0] && apIdle_q) apStart_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (apStart_q) begin
          apStart_d = 1'b0;
          if (dataLen_q == '0) begin
            apDone_d = 1'b1;
          end else begin
            apIdle_d = 1'b0;
            cnt_d    = '0;
            outCnt_d = '0;
            lastIn_d = 1'b0;
            state_d  = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        histClr = 1'b1;
        cnt_d   = cnt_q + TIW'(1);
        if (cnt_q == LAST_TAP) begin
          cnt_d   = '0;
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        if (bus.ss_tvalid) begin
          histShift = 1'b1;
          lastIn_d  = bus.ss_tlast;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = S_MAC;
        end
      end
      // The final MAC cycle loads the output register so valid rises the very next cycle.
      S_MAC: begin
        acc_d = accSum;
        cnt_d = cnt_q + TIW'(1);
        if (cnt_q == LAST_TAP) begin
          cnt_d     = '0;
          smValid_d = 1'b1;
          smData_d  = outVal;
          smLast_d  = lastIn_q || ((outCnt_q + DW'(1)) == dataLen_q);
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.sm_tready) begin
          smValid_d = 1'b0;
          smLast_d  = 1'b0;
          outCnt_d  = outCnt_q + DW'(1);
          if (smLast_q) begin
            apDone_d = 1'b1;
            apIdle_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WAIT_IN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wrAck_q   <= 1'b0;
      arAck_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdCtrl_q  <= 1'b0;
      rdata_q   <= '0;
      apStart_q <= 1'b0;
      apDone_q  <= 1'b0;
      apIdle_q  <= 1'b1;
      dataLen_q <= '0;
      outCnt_q  <= '0;
      acc_q     <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lastIn_q  <= 1'b0;
      smValid_q <= 1'b0;
      smLast_q  <= 1'b0;
      smData_q  <= '0;
      for (int k = 0; k < NTAP; k++) begin
        tap_q[k]  <= '0;
        hist_q[k] <= '0;
      end
    end else begin
      wrAck_q <= bus.awvalid & bus.wvalid & ~wrAck_q;
      arAck_q <= bus.arvalid & ~arAck_q & ~rvalid_q;
      if (arAck_q && bus.arvalid) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdMux;
        rdCtrl_q <= (bus.araddr == ADDR_CTRL);
      end else if (rvalid_q && bus.rready) begin
        rvalid_q <= 1'b0;
      end
      if (wrFire && apIdle_q) begin
        if (bus.awaddr == ADDR_LEN) dataLen_q <= bus.wdata;
        if (wrIsTap) tap_q[wrTapIdx] <= bus.wdata;
      end
      if (histClr) begin
        hist_q[cnt_q] <= '0;
      end else if (histShift) begin
        hist_q[0] <= bus.ss_tdata;
        for (int k = 1; k < NTAP; k++) hist_q[k] <= hist_q[k-1];
      end
      apStart_q <= apStart_d;
      apDone_q  <= apDone_d;
      apIdle_q  <= apIdle_d;
      outCnt_q  <= outCnt_d;
      acc_q     <= acc_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lastIn_q  <= lastIn_d;
      smValid_q <= smValid_d;
      smLast_q  <= smLast_d;
      smData_q  <= smData_d;
    end
  end

  assign bus.awready   = wrAck_q;
  assign bus.wready    = wrAck_q;
  assign bus.arready   = arAck_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.ss_tready = (state_q == S_WAIT_IN) && bus.ss_tvalid;
  assign bus.sm_tvalid = smValid_q;
  assign bus.sm_tdata  = smData_q;
  assign bus.sm_tlast  = smLast_q;

endmodule

// File: tb/tb_fir_stream_engine.sv
// Directed self-checking bench for fir_stream_engine against a wide-accumulator FIR model.
// Expected outputs follow FIR_SATURATE_EN the same way the design build does.
module tb_fir_stream_engine;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int NTAP = 11;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fir_stream_engine_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus();

  fir_stream_engine #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .NTAP(NTAP)) dut (
    .axis_clk (clock),
    .axis_rst (reset),
    .bus      (bus)
  );

  int            checkCount = 0;
  int            errorCount = 0;
  longint        cycCount   = 0;
  longint        firstInCycle = 0;
  logic [DW-1:0] modelTaps [NTAP];
  logic [DW-1:0] xs [$];
  logic [DW-1:0] expQ [$];
  logic [DW-1:0] lastData;

  always @(posedge clock) cycCount <= cycCount + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] clampOut(input logic signed [71:0] s);
`ifdef FIR_SATURATE_EN
    if (s > 72'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -72'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  task automatic buildExpected(input int count);
    logic signed [71:0] s, a, b;
    expQ.delete();
    for (int n = 0; n < count; n++) begin
      s = 0;
      for (int k = 0; k < NTAP; k++) begin
        if (n - k >= 0) begin
          a = $signed(modelTaps[k]);
          b = $signed(xs[n-k]);
          s = s + a * b;
        end
      end
      expQ.push_back(clampOut(s));
    end
  endtask

  task automatic axiWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int budget;
    budget = 0;
    @(posedge clock); #1;
    bus.awaddr = addr; bus.wdata = data; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clock);
    while (!(bus.awready && bus.wready) && budget < 50) begin
      budget++;
      @(negedge clock);
    end
    if (budget >= 50) checkOutput("awready_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic axiRead(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    int budget;
    budget = 0;
    data = '1;
    @(posedge clock); #1;
    bus.araddr = addr; bus.arvalid = 1'b1;
    @(negedge clock);
    while (!bus.arready && budget < 50) begin
      budget++;
      @(negedge clock);
    end
    @(posedge clock); #1;
    bus.arvalid = 1'b0;
    if (budget >= 50) begin
      checkOutput("arready_timeout", 64'd0, 64'd1);
      return;
    end
    budget = 0;
    @(negedge clock);
    while (!bus.rvalid && budget < 50) begin
      budget++;
      @(negedge clock);
    end
    if (budget >= 50) begin
      checkOutput("rvalid_timeout", 64'd0, 64'd1);
      return;
    end
    data = bus.rdata;
    bus.rready = 1'b1;
    @(posedge clock); #1;
    bus.rready = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    logic [DW-1:0] got;
    axiRead(addr, got);
    checkOutput(tag, 64'(got), 64'(expected));
  endtask

  task automatic writeTaps();
    for (int k = 0; k < NTAP; k++) axiWrite(AW'(32 + 4 * k), modelTaps[k]);
  endtask

  task automatic applyStimulus(input int count, input int lastAt);
    int budget;
    @(posedge clock); #1;
    for (int i = 0; i < count; i++) begin
      bus.ss_tdata = xs[i]; bus.ss_tlast = (i == lastAt); bus.ss_tvalid = 1'b1;
      budget = 0;
      @(negedge clock);
      while (!bus.ss_tready && budget < 200) begin
        budget++;
        @(negedge clock);
      end
      if (budget >= 200) begin
        checkOutput("ss_tready_timeout", 64'd0, 64'd1);
        break;
      end
      if (i == 0) firstInCycle = cycCount;
      @(posedge clock); #1;
    end
    bus.ss_tvalid = 1'b0; bus.ss_tlast = 1'b0;
  endtask

  task automatic collectOutputs(input int count, input int stallMax, input bit checkLatency);
    int            budget, stall;
    logic [DW-1:0] held;
    logic          heldLast, extraSeen;
    for (int i = 0; i < count; i++) begin
      budget = 0;
      @(negedge clock);
      while (!bus.sm_tvalid && budget < 500) begin
        budget++;
        @(negedge clock);
      end
      if (budget >= 500) begin
        checkOutput($sformatf("sm_tvalid_timeout[%0d]", i), 64'd0, 64'd1);
        break;
      end
      if (i == 0 && checkLatency) checkOutput("latency", 64'(cycCount - firstInCycle), 64'(NTAP + 1));
      held = bus.sm_tdata; heldLast = bus.sm_tlast;
      stall = (stallMax > 0) ? int'($urandom_range(stallMax, 0)) : 0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        checkOutput("stall_hold", {31'd0, bus.sm_tvalid, bus.sm_tdata}, {31'd0, 1'b1, held});
      end
      bus.sm_tready = 1'b1;
      @(posedge clock); #1;
      bus.sm_tready = 1'b0;
      lastData = held;
      checkOutput($sformatf("y[%0d]", i), 64'(held), 64'(expQ[i]));
      checkOutput($sformatf("tlast[%0d]", i), 64'(heldLast), 64'(i == count - 1));
    end
    extraSeen = 1'b0;
    repeat (2 * NTAP + 6) begin
      @(negedge clock);
      if (bus.sm_tvalid) extraSeen = 1'b1;
    end
    checkOutput("no_extra_output", 64'(extraSeen), 64'd0);
  endtask

  task automatic runFrame(input int count, input int lastAt, input int stallMax, input bit checkLatency);
    buildExpected(count);
    axiWrite(AW'(0), 32'd1);
    fork
      applyStimulus(count, lastAt);
      collectOutputs(count, stallMax, checkLatency);
    join
  endtask

  initial begin
    logic seen;
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    bus.ss_tvalid = 0; bus.ss_tdata = '0; bus.ss_tlast = 0; bus.sm_tready = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    checkOutput("reset_sm_tvalid", 64'(bus.sm_tvalid), 64'd0);
    checkOutput("reset_awready", 64'(bus.awready), 64'd0);
    checkOutput("reset_rvalid", 64'(bus.rvalid), 64'd0);
    readCheck("reset_ctrl", AW'(0), 32'h4);
    readCheck("reset_len", AW'(32'h10), 32'h0);
    readCheck("reset_tap0", AW'(32'h20), 32'h0);

    modelTaps = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63, 32'd56, 32'd23, -32'sd9, -32'sd10, 32'd0};
    writeTaps();
    axiWrite(AW'(32'h10), 32'd600);
    axiWrite(AW'(32'h80), 32'h55);
    readCheck("tap1_readback", AW'(32'h24), 32'hFFFF_FFF6);
    readCheck("tap3_readback", AW'(32'h2C), 32'd23);
    readCheck("len_readback", AW'(32'h10), 32'd600);
    readCheck("unmapped_read", AW'(32'h80), 32'h0);
    readCheck("beyond_last_tap", AW'(32'h4C), 32'h0);

    // Long frame with random output stalls and configuration writes while busy.
    xs.delete();
    for (int n = 0; n < 600; n++) xs.push_back(DW'(n));
    buildExpected(600);
    axiWrite(AW'(0), 32'd1);
    fork
      applyStimulus(600, -1);
      collectOutputs(600, 5, 1'b1);
      begin
        repeat (50) @(posedge clock);
        axiWrite(AW'(32'h24), 32'd99);
        axiWrite(AW'(32'h10), 32'd5);
        readCheck("tap1_busy", AW'(32'h24), 32'hFFFF_FFF6);
        readCheck("ctrl_busy", AW'(0), 32'h0);
      end
    join
    readCheck("ctrl_done", AW'(0), 32'h6);
    readCheck("ctrl_done_cleared", AW'(0), 32'h4);

    // Zero length: start completes immediately and the stream is ignored.
    axiWrite(AW'(32'h10), 32'd0);
    axiWrite(AW'(0), 32'd1);
    bus.ss_tvalid = 1'b1; bus.ss_tdata = 32'd7;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (bus.ss_tready) seen = 1'b1;
    end
    bus.ss_tvalid = 1'b0;
    checkOutput("len0_no_ready", 64'(seen), 64'd0);
    readCheck("len0_ctrl", AW'(0), 32'h6);
    readCheck("len0_ctrl_cleared", AW'(0), 32'h4);

    // ss_tlast ends the frame before data_length is reached.
    axiWrite(AW'(32'h10), 32'd10);
    xs = '{32'd5, -32'sd3, 32'd100, 32'd7};
    runFrame(4, 3, 2, 1'b1);
    readCheck("tlast_ctrl", AW'(0), 32'h6);
    readCheck("tlast_ctrl_cleared", AW'(0), 32'h4);

    // Full-scale taps and samples exercise wrap versus saturation.
    for (int k = 0; k < NTAP; k++) modelTaps[k] = 32'h7FFF_FFFF;
    writeTaps();
    axiWrite(AW'(32'h10), 32'd14);
    xs.delete();
    for (int n = 0; n < 14; n++) xs.push_back(32'h7FFF_FFFF);
    runFrame(14, -1, 0, 1'b0);
`ifdef FIR_SATURATE_EN
    checkOutput("fullscale_last", 64'(lastData), 64'h7FFF_FFFF);
`else
    checkOutput("fullscale_last", 64'(lastData), 64'd11);
`endif
    readCheck("fullscale_ctrl", AW'(0), 32'h6);

    // Reset in the middle of a frame, then a fresh frame from zero history.
    for (int k = 0; k < NTAP; k++) modelTaps[k] = DW'(k + 1);
    writeTaps();
    axiWrite(AW'(32'h10), 32'd20);
    xs = '{32'd9};
    axiWrite(AW'(0), 32'd1);
    applyStimulus(1, -1);
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_sm_tvalid", 64'(bus.sm_tvalid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    readCheck("midreset_ctrl", AW'(0), 32'h4);
    readCheck("midreset_tap0", AW'(32'h20), 32'h0);
    readCheck("midreset_tap2", AW'(32'h28), 32'h0);
    readCheck("midreset_len", AW'(32'h10), 32'h0);
    writeTaps();
    axiWrite(AW'(32'h10), 32'd6);
    xs = '{32'd10, 32'd20, -32'sd30, 32'd40, 32'd50, -32'sd60};
    runFrame(6, 5, 3, 1'b1);
    readCheck("restart_ctrl", AW'(0), 32'h6);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
